// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/response bus between the MEM stage and data memory
//
// Signals:
//   dmem_req   : stage -> memory, access request (held until acknowledged)
//   dmem_we    : stage -> memory, write enable qualified by dmem_req
//   dmem_addr  : stage -> memory, byte address
//   dmem_wdata : stage -> memory, store data
//   dmem_rdata : memory -> stage, load data, valid with dmem_ack
//   dmem_ack   : memory -> stage, single-cycle completion strobe
// Modports: master (MEM stage side), slave (memory side).

interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage with stalling data-memory handshake and MEM/WB register
//
// Purpose: issues loads/stores to data memory, stalls the front of the pipeline
// until the memory acknowledges, and registers the MEM/WB fields.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject word-misaligned accesses
// (no request, bubble, one-cycle misalign_fault pulse).
//
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   *_in                  : EX/MEM control and data fields (held stable by upstream while stall=1)
//   dmem                  : data-memory bus (mem_stage_if.master)
//   stall                 : hold PC, IF/ID, ID/EX and EX/MEM
//   pc_src                : branch taken
//   *_out, read_data_out  : registered MEM/WB fields
//   misalign_fault        : alignment error pulse (tied 0 without MEM_ALIGN_CHECK_EN)

module mem_stage (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_to_reg_in,
  input  logic               reg_write_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic               beq_instruction_in,
  input  logic               flag_beq_in,
  input  logic [31:0]        alu_result_in,
  input  logic [31:0]        mux2_result_in,
  input  logic [4:0]         reg_rd_in,
  mem_stage_if.master        dmem,
  output logic               stall,
  output logic               pc_src,
  output logic               mem_to_reg_out,
  output logic               reg_write_out,
  output logic [31:0]        read_data_out,
  output logic [31:0]        alu_result_out,
  output logic [4:0]         reg_rd_out,
  output logic               misalign_fault
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        reg_write_q, reg_write_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  reg_rd_q, reg_rd_d;
  logic        misalign_q, misalign_d;

  logic access;
  logic misaligned;
  logic issue;
  logic is_load;
  logic req_c;
  logic stall_c;

  assign access  = mem_read_in | mem_write_in;
  // Read and write together is treated as a store, so no load data is returned.
  assign is_load = mem_read_in & ~mem_write_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = access & (alu_result_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign issue = access & ~misaligned;

  always_comb begin
    state_d      = state_q;
    // Bubble by default: control bits cleared, data fields simply follow the inputs.
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    read_data_d  = 32'h0;
    alu_result_d = alu_result_in;
    reg_rd_d     = reg_rd_in;
    misalign_d   = 1'b0;
    req_c        = 1'b0;
    stall_c      = 1'b0;
    case (state_q)
      IDLE: begin
        // dmem_ack is deliberately not looked at here.
        if (issue) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          state_d = BUSY;
        end else if (misaligned) begin
          misalign_d = 1'b1;
        end else begin
          mem_to_reg_d = mem_to_reg_in;
          reg_write_d  = reg_write_in;
        end
      end
      BUSY: begin
        req_c   = 1'b1;
        stall_c = ~dmem.dmem_ack;
        if (dmem.dmem_ack) begin
          state_d      = IDLE;
          mem_to_reg_d = mem_to_reg_in;
          reg_write_d  = reg_write_in;
          read_data_d  = is_load ? dmem.dmem_rdata : 32'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      read_data_q  <= 32'h0;
      alu_result_q <= 32'h0;
      reg_rd_q     <= 5'h0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      reg_rd_q     <= reg_rd_d;
      misalign_q   <= misalign_d;
    end
  end

  // Handshake and hazard outputs are gated by reset so they drop the moment reset asserts.
  assign dmem.dmem_req   = reset & req_c;
  assign dmem.dmem_we    = mem_write_in & dmem.dmem_req;
  assign dmem.dmem_addr  = alu_result_in;
  assign dmem.dmem_wdata = mux2_result_in;
  assign stall           = reset & stall_c;
  assign pc_src          = reset & beq_instruction_in & flag_beq_in;

  assign mem_to_reg_out  = mem_to_reg_q;
  assign reg_write_out   = reg_write_q;
  assign read_data_out   = read_data_q;
  assign alu_result_out  = alu_result_q;
  assign reg_rd_out      = reg_rd_q;
  assign misalign_fault  = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

  logic        clock;
  logic        reset;
  logic        mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in;
  logic        beq_instruction_in, flag_beq_in;
  logic [31:0] alu_result_in, mux2_result_in;
  logic [4:0]  reg_rd_in;
  logic        stall, pc_src, mem_to_reg_out, reg_write_out, misalign_fault;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  reg_rd_out;

  mem_stage_if dif ();

  mem_stage dut (
    .clock              (clock),
    .reset              (reset),
    .mem_to_reg_in      (mem_to_reg_in),
    .reg_write_in       (reg_write_in),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .beq_instruction_in (beq_instruction_in),
    .flag_beq_in        (flag_beq_in),
    .alu_result_in      (alu_result_in),
    .mux2_result_in     (mux2_result_in),
    .reg_rd_in          (reg_rd_in),
    .dmem               (dif.master),
    .stall              (stall),
    .pc_src             (pc_src),
    .mem_to_reg_out     (mem_to_reg_out),
    .reg_write_out      (reg_write_out),
    .read_data_out      (read_data_out),
    .alu_result_out     (alu_result_out),
    .reg_rd_out         (reg_rd_out),
    .misalign_fault     (misalign_fault)
  );

  typedef struct {
    logic        mtr, rw, beq, flg, ack;
    logic [31:0] alu, rdata;
    logic [4:0]  rd;
    logic        e_pc, e_mtr, e_rw;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
  } vec_t;

  typedef struct {
    logic        bub;
    logic        mtr, rw;
    logic [31:0] rdat, alu;
    logic [4:0]  rd;
    logic        mf;
  } mwb_t;

  mwb_t sb[$];
  vec_t v[6];
  int   n_vec = 0;
  int   n_bad = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic comb(input logic req, input logic we, input logic stl);
    chk("dmem_req", {31'h0, dif.dmem_req}, {31'h0, req});
    chk("dmem_we",  {31'h0, dif.dmem_we},  {31'h0, we});
    chk("stall",    {31'h0, stall},        {31'h0, stl});
  endtask

  function automatic mwb_t bubble(input logic mf);
    mwb_t e;
    e.bub = 1'b1; e.mtr = 1'b0; e.rw = 1'b0; e.rdat = 32'h0; e.alu = 32'h0; e.rd = 5'h0; e.mf = mf;
    return e;
  endfunction

  function automatic mwb_t full(input logic mtr, input logic rw, input logic [31:0] rdat,
                                input logic [31:0] alu, input logic [4:0] rd);
    mwb_t e;
    e.bub = 1'b0; e.mtr = mtr; e.rw = rw; e.rdat = rdat; e.alu = alu; e.rd = rd; e.mf = 1'b0;
    return e;
  endfunction

  task automatic tick(input mwb_t e);
    mwb_t x;
    sb.push_back(e);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    chk("reg_write_out",  {31'h0, reg_write_out},  {31'h0, x.rw});
    chk("mem_to_reg_out", {31'h0, mem_to_reg_out}, {31'h0, x.mtr});
    chk("misalign_fault", {31'h0, misalign_fault}, {31'h0, x.mf});
    if (!x.bub) begin
      chk("read_data_out",  read_data_out,          x.rdat);
      chk("alu_result_out", alu_result_out,         x.alu);
      chk("reg_rd_out",     {27'h0, reg_rd_out},    {27'h0, x.rd});
    end
  endtask

  task automatic set_in(input logic mr, input logic mw, input logic mtr, input logic rw,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    mem_read_in = mr; mem_write_in = mw; mem_to_reg_in = mtr; reg_write_in = rw;
    alu_result_in = alu; mux2_result_in = wd; reg_rd_in = rd;
  endtask

  initial begin
    v[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         5'd5,  1'b0, 1'b0, 1'b1, 32'h0000_0010, 5'd5};
    v[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_0000, 32'h0,         5'd31, 1'b1, 1'b0, 1'b0, 32'hCAFE_0000, 5'd31};
    v[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         5'd0,  1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 5'd0};
    v[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'h5A5A_5A5A, 5'd12, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 5'd12};
    v[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0,         5'd17, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 5'd17};
    v[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         5'd0,  1'b0, 1'b0, 1'b0, 32'h0,         5'd0};

    // Reset: outputs forced low even with an access and a taken branch presented.
    reset = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h1, 5'd3);
    beq_instruction_in = 1'b1; flag_beq_in = 1'b1;
    dif.dmem_ack = 1'b0; dif.dmem_rdata = 32'h0;
    #3;
    comb(1'b0, 1'b0, 1'b0);
    chk("pc_src_rst", {31'h0, pc_src}, 32'h0);
    chk("rst_reg_write", {31'h0, reg_write_out}, 32'h0);
    chk("rst_read_data", read_data_out, 32'h0);
    chk("rst_alu", alu_result_out, 32'h0);
    chk("rst_misalign", {31'h0, misalign_fault}, 32'h0);
    beq_instruction_in = 1'b0; flag_beq_in = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;

    // Non-memory instructions, one cycle latency, ack ignored in IDLE.
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 1'b0, v[i].mtr, v[i].rw, v[i].alu, 32'h0, v[i].rd);
      beq_instruction_in = v[i].beq; flag_beq_in = v[i].flg;
      dif.dmem_ack = v[i].ack; dif.dmem_rdata = v[i].rdata;
      #1;
      chk("pc_src", {31'h0, pc_src}, {31'h0, v[i].e_pc});
      comb(1'b0, 1'b0, 1'b0);
      tick(full(v[i].e_mtr, v[i].e_rw, 32'h0, v[i].e_alu, v[i].e_rd));
    end
    beq_instruction_in = 1'b0; flag_beq_in = 1'b0; dif.dmem_ack = 1'b0;

    // Load at 0x40, ack after three waiting BUSY cycles: stall high four cycles.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd7);
    #1;
    comb(1'b1, 1'b0, 1'b1);
    chk("dmem_addr", dif.dmem_addr, 32'h40);
    tick(bubble(1'b0));
    for (int k = 0; k < 3; k++) begin
      #1;
      comb(1'b1, 1'b0, 1'b1);
      tick(bubble(1'b0));
    end
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    comb(1'b1, 1'b0, 1'b0);
    tick(full(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h40, 5'd7));
    // Access still held after ack: fresh IDLE request, one bubble in between.
    dif.dmem_ack = 1'b0;
    #1;
    comb(1'b1, 1'b0, 1'b1);
    tick(bubble(1'b0));
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h0102_0304;
    #1;
    comb(1'b1, 1'b0, 1'b0);
    tick(full(1'b1, 1'b1, 32'h0102_0304, 32'h40, 5'd7));
    dif.dmem_ack = 1'b0;

    // Store at 0x44, ack in first BUSY cycle.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h1234_5678, 5'd9);
    #1;
    comb(1'b1, 1'b1, 1'b1);
    chk("dmem_wdata", dif.dmem_wdata, 32'h1234_5678);
    tick(bubble(1'b0));
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hFFFF_FFFF;
    #1;
    comb(1'b1, 1'b1, 1'b0);
    chk("dmem_wdata", dif.dmem_wdata, 32'h1234_5678);
    tick(full(1'b0, 1'b0, 32'h0, 32'h44, 5'd9));
    dif.dmem_ack = 1'b0;

    // Read and write together behaves as a store.
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h48, 32'h55, 5'd3);
    #1;
    comb(1'b1, 1'b1, 1'b1);
    tick(bubble(1'b0));
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hAAAA_5555;
    #1;
    comb(1'b1, 1'b1, 1'b0);
    tick(full(1'b1, 1'b1, 32'h0, 32'h48, 5'd3));
    dif.dmem_ack = 1'b0;

    // Reset pulse in the second BUSY cycle.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 5'd4);
    #1;
    comb(1'b1, 1'b0, 1'b1);
    tick(bubble(1'b0));
    #1;
    comb(1'b1, 1'b0, 1'b1);
    tick(bubble(1'b0));
    reset = 1'b0;
    #1;
    comb(1'b0, 1'b0, 1'b0);
    chk("rstb_reg_write", {31'h0, reg_write_out}, 32'h0);
    chk("rstb_mem_to_reg", {31'h0, mem_to_reg_out}, 32'h0);
    chk("rstb_alu", alu_result_out, 32'h0);
    chk("rstb_reg_rd", {27'h0, reg_rd_out}, 32'h0);
    #1;
    reset = 1'b1;
    #1;
    comb(1'b1, 1'b0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h90, 32'h0, 5'd6);
    #1;
    comb(1'b0, 1'b0, 1'b0);
    tick(full(1'b0, 1'b1, 32'h0, 32'h90, 5'd6));
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hBAD0_BAD0;
    #1;
    comb(1'b0, 1'b0, 1'b0);
    tick(full(1'b0, 1'b1, 32'h0, 32'h90, 5'd6));
    dif.dmem_ack = 1'b0;

    // Misaligned load at 0x42.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h42, 32'h0, 5'd8);
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    comb(1'b0, 1'b0, 1'b0);
    tick(bubble(1'b1));
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    comb(1'b0, 1'b0, 1'b0);
    tick(full(1'b0, 1'b0, 32'h0, 32'h0, 5'd0));
`else
    #1;
    comb(1'b1, 1'b0, 1'b1);
    chk("dmem_addr_raw", dif.dmem_addr, 32'h42);
    tick(bubble(1'b0));
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h1111_2222;
    #1;
    comb(1'b1, 1'b0, 1'b0);
    tick(full(1'b1, 1'b1, 32'h1111_2222, 32'h42, 5'd8));
    dif.dmem_ack = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
